// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - instruction decode and execute sequencer downstream of fetch.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (illegal system ops halt and set illegal_inst).
package cpu_common;
  typedef enum logic {FETCH_NOP = 1'b0, FETCH_INC_PC = 1'b1} fetch_operation_t;
endpackage

module decode_ctrl #(
  parameter int RETIRE_CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            rst_async,
  input  logic                            fetch_complete,
  input  logic [15:0]                     inst,
  output cpu_common::fetch_operation_t    fetch_operation,
  output logic [2:0]                      rf_rd_sel,
  output logic                            rf_write_en,
  output logic [1:0]                      rf_wdata_sel,
  output logic [2:0]                      alu_op,
  output logic                            alu_b_imm,
  output logic [7:0]                      imm,
  output logic                            mem_req,
  output logic                            mem_we,
  input  logic                            mem_ack,
  output logic                            halted,
  output logic                            illegal_inst,
  output logic [RETIRE_CNT_W-1:0]         retired
);

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_WAIT_FETCH, S_EXEC, S_MEM_WAIT, S_SETTLE, S_HALT
  } state_t;

  state_t                  state_q;
  logic [15:0]             ir_q;
  logic                    illegal_q;
  logic [RETIRE_CNT_W-1:0] retired_q;

  logic [1:0] ir_type;
  logic [2:0] ir_op;
  logic       is_alu, is_sys, is_mem, sys_halt, trap;
  logic       in_exec, mem_phase, mem_done;

  assign ir_type  = ir_q[1:0];
  assign ir_op    = ir_q[7:5];
  assign is_alu   = (ir_type == 2'd0) || (ir_type == 2'd2);
  assign is_sys   = (ir_type == 2'd1);
  assign is_mem   = (ir_type == 2'd3);
  assign sys_halt = is_sys && (ir_op == 3'd1);
  assign trap     = TrapEn && is_sys && (ir_op[2:1] != 2'd0);

  assign rf_rd_sel    = ir_q[4:2];
  assign alu_op       = ir_op;
  assign imm          = ir_q[15:8];
  assign alu_b_imm    = (ir_type == 2'd2);
  assign rf_wdata_sel = is_mem ? 2'd2 : ((ir_type == 2'd2) && (ir_op == 3'd0)) ? 2'd1 : 2'd0;

  // The request is live from the EXEC cycle so an ack in that very cycle completes the access.
  assign in_exec   = (state_q == S_EXEC);
  assign mem_phase = (in_exec && is_mem) || (state_q == S_MEM_WAIT);
  assign mem_done  = mem_phase && mem_ack;

  assign mem_req      = mem_phase;
  assign mem_we       = mem_phase && ir_q[5];
  assign rf_write_en  = (in_exec && is_alu) || (mem_done && !ir_q[5]);
  assign halted       = (state_q == S_HALT);
  assign illegal_inst = illegal_q;
  assign retired      = retired_q;

  always_comb begin
    fetch_operation = cpu_common::FETCH_NOP;
    if ((in_exec && (is_alu || (is_sys && !sys_halt && !trap))) || mem_done)
      fetch_operation = cpu_common::FETCH_INC_PC;
  end

  always_ff @(posedge clk) begin
    if (rst_async) begin
      state_q   <= S_WAIT_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_WAIT_FETCH: begin
          if (fetch_complete) begin
            ir_q    <= inst;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem) begin
            if (mem_ack) begin
              retired_q <= retired_q + RETIRE_CNT_W'(1);
              state_q   <= S_SETTLE;
            end else begin
              state_q <= S_MEM_WAIT;
            end
          end else if (sys_halt || trap) begin
            if (sys_halt) retired_q <= retired_q + RETIRE_CNT_W'(1);
            if (trap) illegal_q <= 1'b1;
            state_q <= S_HALT;
          end else begin
            retired_q <= retired_q + RETIRE_CNT_W'(1);
            state_q   <= S_SETTLE;
          end
        end
        S_MEM_WAIT: begin
          if (mem_ack) begin
            retired_q <= retired_q + RETIRE_CNT_W'(1);
            state_q   <= S_SETTLE;
          end
        end
        // fetch still reports the old instruction here, so fetch_complete must be ignored.
        S_SETTLE: state_q <= S_WAIT_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_WAIT_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// tb/tb_decode_ctrl.sv - scoreboard bench for decode_ctrl with a fetch/memory stimulus model.
// Honors DECODE_ILLEGAL_TRAP_EN to select the expected illegal-op behaviour.
module tb_decode_ctrl;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fc = 1'b0;
  logic [15:0] inst = '0;
  logic mem_ack = 1'b0;
  cpu_common::fetch_operation_t fetch_operation;
  logic [2:0] rf_rd_sel, alu_op;
  logic rf_write_en, alu_b_imm, mem_req, mem_we, halted, illegal_inst;
  logic [1:0] rf_wdata_sel;
  logic [7:0] imm;
  logic [15:0] retired;

  decode_ctrl #(.RETIRE_CNT_W(16)) dut (
    .clk(clk), .rst_async(rst), .fetch_complete(fc), .inst(inst),
    .fetch_operation(fetch_operation), .rf_rd_sel(rf_rd_sel), .rf_write_en(rf_write_en),
    .rf_wdata_sel(rf_wdata_sel), .alu_op(alu_op), .alu_b_imm(alu_b_imm), .imm(imm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .halted(halted),
    .illegal_inst(illegal_inst), .retired(retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        we;
    logic [1:0]  wsel;
    logic [2:0]  rd;
    logic [2:0]  op;
    logic        bimm;
    logic [7:0]  imm;
    bit          care_alu;
    bit          care_imm;
    int          mem_cyc;
    logic        mem_we;
    int unsigned ret;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;
  int unsigned model_ret = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with a write strobe or a PC advance must match the next expected event.
  int   run = 0;
  bit   prev_mem_evt = 0;
  bit   evt;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      prev_mem_evt = 0;
    end else begin
      if (prev_mem_evt) chk("mem_req_drop", 64'(mem_req), 64'd0);
      run = mem_req ? run + 1 : 0;
      evt = rf_write_en || (fetch_operation == cpu_common::FETCH_INC_PC);
      prev_mem_evt = evt && mem_req;
      if (evt) begin
        if (sbq.size() == 0) begin
          chk("unexpected_event", 64'(rf_write_en) << 1 | 64'(fetch_operation), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("event_cycle", 64'(cyc), 64'(e.cyc));
          chk("write_en", 64'(rf_write_en), 64'(e.we));
          chk("inc_pc", 64'(fetch_operation), 64'(cpu_common::FETCH_INC_PC));
          chk("retired", 64'(retired), 64'(e.ret[15:0]));
          chk("mem_req_cycles", 64'(run), 64'(e.mem_cyc));
          chk("mem_we", 64'(mem_req ? mem_we : 1'b0), 64'(e.mem_we));
          if (e.we) begin
            chk("rd_sel", 64'(rf_rd_sel), 64'(e.rd));
            chk("wdata_sel", 64'(rf_wdata_sel), 64'(e.wsel));
          end
          if (e.care_alu) begin
            chk("alu_op", 64'(alu_op), 64'(e.op));
            chk("alu_b_imm", 64'(alu_b_imm), 64'(e.bimm));
          end
          if (e.care_imm) chk("imm", 64'(imm), 64'(e.imm));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; fc = 1'b0; mem_ack = 1'b0;
    step();
    step();
    chk("rst_fetch_op", 64'(fetch_operation), 64'(cpu_common::FETCH_NOP));
    chk("rst_write_en", 64'(rf_write_en), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_illegal", 64'(illegal_inst), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_pending_events", 64'(sbq.size()), 64'd0);
    sbq.delete();
    model_ret = 0;
    rst = 1'b0;
  endtask

  // Acts as fetch and data memory for one instruction; called with the DUT in WAIT_FETCH.
  task automatic run_inst(input logic [15:0] ins, input int dly);
    logic [1:0] typ;
    logic [2:0] op;
    bit is_mem, is_halt, is_trap;
    exp_t x;
    typ = ins[1:0];
    op = ins[7:5];
    is_mem = (typ == 2'd3);
    is_trap = TRAP && (typ == 2'd1) && (op >= 3'd2);
    is_halt = ((typ == 2'd1) && (op == 3'd1)) || is_trap;
    inst = ins;
    fc = 1'b1;
    mem_ack = is_mem && (dly == 0);
    if (!is_halt) begin
      x.cyc = cyc + 1 + (is_mem ? dly : 0);
      x.we = (typ == 2'd0) || (typ == 2'd2) || (is_mem && !ins[5]);
      x.wsel = is_mem ? 2'd2 : ((typ == 2'd2) && (op == 3'd0)) ? 2'd1 : 2'd0;
      x.rd = ins[4:2];
      x.op = op;
      x.bimm = (typ == 2'd2);
      x.imm = ins[15:8];
      x.care_alu = (typ == 2'd0) || (typ == 2'd2);
      x.care_imm = (typ == 2'd2) || is_mem;
      x.mem_cyc = is_mem ? dly + 1 : 0;
      x.mem_we = is_mem && ins[5];
      x.ret = model_ret;
      sbq.push_back(x);
      model_ret++;
    end
    if (is_mem) begin
      repeat (1 + dly) step();
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      step();
    end else if (!is_halt) begin
      repeat (3) step();
    end else begin
      if (!is_trap) model_ret++;
      repeat (2) step();
      chk("halted", 64'(halted), 64'd1);
      chk("illegal_inst", 64'(illegal_inst), 64'(is_trap));
      chk("halt_retired", 64'(retired), 64'(model_ret[15:0]));
      chk("halt_fetch_op", 64'(fetch_operation), 64'(cpu_common::FETCH_NOP));
      repeat (4) begin
        inst = 16'($urandom);
        fc = 1'($urandom);
        mem_ack = 1'($urandom);
        step();
      end
      chk("halt_sticky", 64'(halted), 64'd1);
      chk("halt_retired_hold", 64'(retired), 64'(model_ret[15:0]));
      do_reset();
    end
  endtask

  task automatic gap(input int n);
    fc = 1'b0;
    repeat (n) begin
      inst = 16'($urandom);
      mem_ack = 1'($urandom);
      step();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    step();
    do_reset();
    run_inst(16'h00E8, 0);
    chk("retired_after_alu", 64'(retired), 64'd1);
    run_inst(16'h5A02, 0);
    run_inst(16'h1003, 3);
    chk("retired_after_load", 64'(retired), 64'd3);
    gap(1);
    run_inst(16'h4423, 0);
    // Store that is reset while waiting for its ack; a late ack afterwards must do nothing.
    inst = 16'h0837;
    fc = 1'b1;
    mem_ack = 1'b0;
    step();
    step();
    chk("store_req_pending", 64'(mem_req), 64'd1);
    rst = 1'b1;
    fc = 1'b0;
    step();
    rst = 1'b0;
    model_ret = 0;
    sbq.delete();
    chk("mid_reset_mem_req", 64'(mem_req), 64'd0);
    chk("mid_reset_write", 64'(rf_write_en), 64'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("late_ack_retired", 64'(retired), 64'd0);
    run_inst(16'h0021, 0);
    run_inst(16'h0041, 0);
    chk("illegal_retired", 64'(retired), 64'(model_ret[15:0]));
    for (int i = 0; i < 300; i++) begin
      run_inst(16'($urandom), int'($urandom_range(0, 4)));
      gap(int'($urandom_range(0, 2)));
    end
    step();
    step();
    chk("final_pending_events", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Instruction decode and control sequencer, directly downstream of `fetch`. It waits for `fetch_complete`, latches `inst` into an instruction register, and decodes it. It then drives register-file, ALU and data-memory controls, and tells `fetch` when to advance the PC through `fetch_operation`. It owns the CPU's top-level execute sequence and the halted state.

## Interface
- `RETIRE_CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1  CPU clock; all state updates on the rising edge.
- `rst_async`  in  1  reset, **synchronous, active-high** (port name kept for consistency with the CPU).
- `fetch_complete`  in  1  `inst` is valid this cycle.
- `inst`  in  16  instruction from `fetch`; bits [15:8] are meaningful only for 2-byte instructions.
- `fetch_operation`  out  `cpu_common::fetch_operation_t`  `FETCH_NOP` or `FETCH_INC_PC`.
- `rf_rd_sel`  out  3  destination/first-operand register index (`ir[4:2]`).
- `rf_write_en`  out  1  one-cycle write strobe.
- `rf_wdata_sel`  out  2  write data source: 0 = ALU, 1 = immediate, 2 = memory.
- `alu_op`  out  3  ALU function (`ir[7:5]`).
- `alu_b_imm`  out  1  ALU B operand: 1 = immediate, 0 = r0.
- `imm`  out  8  `ir[15:8]`.
- `mem_req`  out  1  data memory request; held high until acknowledged.
- `mem_we`  out  1  1 = store, 0 = load; valid while `mem_req` is high.
- `mem_ack`  in  1  data memory done.
- `halted`  out  1  CPU stopped.
- `illegal_inst`  out  1  sticky; set on an illegal opcode (see Configuration).
- `retired`  out  `RETIRE_CNT_W`  count of completed instructions.

## Operation
- Instruction format (`ir[1:0]` is the type; `ir[1]` = 1 means 2 bytes):
  - Type 0: ALU, `rd <= rd op r0`.
  - Type 1: system. op 000 = NOP, op 001 = HALT, op 010–111 = illegal.
  - Type 2: immediate. op 000 = `rd <= imm`; otherwise `rd <= rd op imm`.
  - Type 3: memory. `ir[5]` = 1 store, 0 load; address is formed externally from `imm` and `r7`.
- State `WAIT_FETCH`:
  - `fetch_operation` = `FETCH_NOP`.
  - On `fetch_complete` = 1: `ir <= inst`, go to `EXEC`.
- State `EXEC` (one cycle, decodes `ir`):
  - Type 0/2: `rf_write_en` = 1, `fetch_operation` = `FETCH_INC_PC`, `retired`++, go to `SETTLE`.
  - Type 1 NOP: `FETCH_INC_PC`, `retired`++, go to `SETTLE`.
  - Type 1 HALT: `retired`++, go to `HALT`; no PC increment.
  - Type 3: assert `mem_req`, go to `MEM_WAIT`.
- State `MEM_WAIT`:
  - `mem_req` = 1 and `mem_we` stay stable until `mem_ack`.
  - On the `mem_ack` cycle: deassert `mem_req` the next cycle. For a load, `rf_write_en` = 1 with `rf_wdata_sel` = 2 in the ack cycle. Also `FETCH_INC_PC`, `retired`++, go to `SETTLE`.
- State `SETTLE` (one cycle):
  - `fetch_operation` = `FETCH_NOP`; `fetch_complete` is ignored.
  - Reason: `fetch` still reports complete for the old instruction in the cycle after `FETCH_INC_PC`.
  - Go to `WAIT_FETCH`.
- State `HALT`:
  - `halted` = 1, all strobes 0, `FETCH_NOP`.
  - Left only by reset.
- `retired` wraps modulo 2^`RETIRE_CNT_W`.
- Decoded outputs (`rf_rd_sel`, `alu_op`, `alu_b_imm`, `imm`, `rf_wdata_sel`) are combinational from `ir` in every state.

## Timing
- Reset (synchronous, has priority over all transitions):
  - State → `WAIT_FETCH`; `ir` = 0.
  - `fetch_operation` = `FETCH_NOP`; `rf_write_en`, `mem_req`, `mem_we`, `halted`, `illegal_inst` = 0; `retired` = 0.
- Reset asserted mid-`MEM_WAIT` drops `mem_req` on the next edge; a late `mem_ack` is ignored in `WAIT_FETCH`.
- Register/immediate instruction: `fetch_complete` sampled at cycle N; write and `INC_PC` at N+1; `SETTLE` at N+2; next fetch accepted at N+3 at the earliest.
- Memory instruction: `mem_req` rises at N+1. An ack at cycle M gives write/`INC_PC` at M; `SETTLE` at M+1.
- `mem_ack` arriving in the same cycle `mem_req` first rises is legal and completes in that cycle.
- `mem_ack` outside `MEM_WAIT` is ignored.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - Type 1 op 010–111 sets `illegal_inst` and goes to `HALT`.
  - No PC increment and no `retired`++.
- `DECODE_ILLEGAL_TRAP_EN` undefined:
  - Illegal ops execute as NOP (including `retired`++).
  - `illegal_inst` is tied to 0.

## Test plan
- Reset, then `inst` = 0x00E8 (type 0, rd = 2, op = 7) with `fetch_complete` held high → `rf_write_en` = 1 with `rf_rd_sel` = 2 and `alu_op` = 7 exactly one cycle after acceptance; `FETCH_INC_PC` the same cycle; `fetch_complete` in the following cycle ignored; `retired` = 1.
- `inst` = 0x5A02 (type 2, op 0, rd 0) → `rf_wdata_sel` = 1, `imm` = 0x5A, single write strobe.
- Load `inst` = 0x1003 with `mem_ack` delayed 3 cycles → `mem_req` high for exactly 4 cycles; write and `INC_PC` in the ack cycle; `retired` increments once.
- Store with `mem_ack` in the same cycle as the `mem_req` rise, and reset asserted mid-`MEM_WAIT` on a second store → single-cycle request in the first case; in the second, `mem_req` low after reset and no write.
- HALT `inst` = 0x0021 → `halted` = 1 and no `INC_PC`; further `fetch_complete` pulses have no effect until reset.
- Illegal `inst` = 0x0041, run with and without `DECODE_ILLEGAL_TRAP_EN` → halt with `illegal_inst` = 1 versus NOP with `INC_PC` and `retired`++.
